line_mem_bridge: RTL and testbench
==================================

Name: line_mem_bridge

Overview:
- Sits directly downstream of the coherent cache system's snoop-bus memory port.
- Accepts whole-line read and write requests (mem_read/mem_write, line-wide data, mem_ready completion pulse).
- Serialises each request into BEATS word transactions on a req/ack word-RAM port, and assembles read beats back into a line.
- Adds a per-beat timeout with a sticky error flag, so a hung RAM cannot deadlock the coherence bus.

Parameters:
ADDR_WIDTH, 32, byte address width
LINE_SIZE, 32, line size in bytes; power of two
WORD_WIDTH, 32, RAM data width in bits; divides LINE_SIZE*8; BEATS = LINE_SIZE*8/WORD_WIDTH
TIMEOUT, 255, max cycles to wait for ram_ack per beat; >=1

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
mem_read  input  1  line read request; held until mem_ready
mem_write  input  1  line write request; held until mem_ready
mem_addr  input  ADDR_WIDTH  line address; low log2(LINE_SIZE) bits ignored
mem_write_data  input  LINE_SIZE*8  line to write; byte 0 at bits [7:0]
mem_read_data  output  LINE_SIZE*8  assembled read line
mem_ready  output  1  one-cycle completion pulse
ram_req  output  1  word request
ram_we  output  1  1 = write beat
ram_addr  output  ADDR_WIDTH  word byte-address
ram_wdata  output  WORD_WIDTH  write beat data
ram_rdata  input  WORD_WIDTH  read data; valid in the ram_ack cycle
ram_ack  input  1  beat complete; sampled only while ram_req=1
busy  output  1  high in any state other than IDLE
err_timeout  output  1  sticky; set on any beat timeout

Behaviour:
- One clock, clk. Reset is synchronous and active-low (rst_n). Reset is sampled at the rising edge only.
- Reset values: state IDLE, all outputs 0, line buffer 0, beat counter 0, timeout counter 0, err_timeout 0.
- Reset asserted mid-transfer aborts it:
  - IDLE at the next edge; ram_req low after that edge.
  - No mem_ready pulse for the aborted request.
  - Partial buffer contents discarded (cleared).
- States: IDLE, RD_BEAT, WR_BEAT, DONE.
- IDLE:
  - If mem_write=1, latch base = mem_addr with low log2(LINE_SIZE) bits zeroed, latch mem_write_data, go to WR_BEAT.
  - Else if mem_read=1, latch base, go to RD_BEAT.
  - Write has priority when both are high; only the write is served and a single mem_ready results.
  - Upstream inputs are not sampled again until the next IDLE.
- RD_BEAT / WR_BEAT:
  - ram_req=1; ram_we=1 in WR_BEAT only.
  - ram_addr = base + beat*(WORD_WIDTH/8).
  - ram_wdata = latched line bits [beat*WORD_WIDTH +: WORD_WIDTH].
  - Beats run in ascending order from 0; there is no critical-word-first ordering.
  - Outputs are held stable until ram_ack=1. On ack: a read captures ram_rdata into buffer slice [beat*WORD_WIDTH +: WORD_WIDTH], then the beat counter increments.
  - Ack on beat BEATS-1: go to DONE. ram_req is low in DONE.
  - ram_ack may be high in the same cycle as ram_req (zero-wait), giving one beat per cycle.
- Timeout:
  - The counter resets on each new beat and increments every cycle ram_req=1 without ack.
  - If it reaches TIMEOUT without ack:
    - Set err_timeout.
    - For a read, store 0 in that slice.
    - Advance to the next beat as if acked.
  - A transfer always completes, so upstream never hangs.
- DONE:
  - mem_ready=1 for exactly one cycle, then IDLE.
  - mem_read_data = buffer; it is valid from the DONE cycle and held until the next read completes.
  - Write transfers do not modify the buffer.
- Latency with a zero-wait RAM: request seen in IDLE cycle N -> beats in cycles N+1..N+BEATS -> mem_ready in cycle N+BEATS+1. With 8 beats, mem_ready comes 9 cycles after the request cycle.
- Back-to-back: upstream drops its request after the mem_ready edge, so IDLE lasts at least one cycle between transfers.
- Beat addressing wraps modulo 2^ADDR_WIDTH; no bounds check.
- err_timeout is cleared only by reset.

Test Plan:
- Read, zero-wait RAM preloaded with word[k]=0x1000+k, mem_addr=0x0000_0047 -> ram_addr 0x40,0x44..0x5C in consecutive cycles; mem_ready 9 cycles after request; mem_read_data word k = 0x1000+k.
- Write line with word k = 0xA0+k to 0x80, RAM ack delayed 3 cycles per beat -> 8 beats, ram_we=1, ram_wdata 0xA0..0xA7 at 0x80..0x9C; each beat held 4 cycles; single mem_ready pulse.
- mem_read and mem_write both high, addr 0x100 -> only write beats issued; one mem_ready; read buffer unchanged.
- RAM never acks beat 3 of a read, TIMEOUT=4 -> beat 3 abandoned after 4 cycles; err_timeout=1 and stays 1; word 3 of mem_read_data = 0; other words correct; mem_ready asserted.
- rst_n low during beat 5 of a write -> IDLE and ram_req=0 after the reset edge; no mem_ready; a new read afterwards completes normally with err_timeout=0.
- Two reads back-to-back (0x200 then 0x300), upstream drops request on the mem_ready edge -> exactly 8 beats each, one IDLE cycle between, second line data correct, first line held until second DONE.

Source files
------------

// File: rtl/line_mem_bridge_if.sv
// Upstream line port and downstream word-RAM port of the line memory bridge.
// slave: the bridge's view. master: the view of whatever drives the line
// requests and models the RAM.
interface line_mem_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_SIZE  = 32,
  parameter int WORD_WIDTH = 32
);
  logic                    mem_read;
  logic                    mem_write;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [LINE_SIZE*8-1:0]  mem_write_data;
  logic [LINE_SIZE*8-1:0]  mem_read_data;
  logic                    mem_ready;

  logic                    ram_req;
  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [WORD_WIDTH-1:0]   ram_wdata;
  logic [WORD_WIDTH-1:0]   ram_rdata;
  logic                    ram_ack;

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_write_data, ram_rdata, ram_ack,
    output mem_read_data, mem_ready, ram_req, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output mem_read, mem_write, mem_addr, mem_write_data, ram_rdata, ram_ack,
    input  mem_read_data, mem_ready, ram_req, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/line_mem_bridge.sv
// Line-to-word bridge: turns whole-line reads/writes into BEATS ascending
// word transactions on a req/ack RAM port, with a per-beat timeout so a hung
// RAM can never stall the upstream bus.
//
// state   | meaning
// IDLE    | waiting for mem_write (priority) or mem_read
// RD_BEAT | issuing read beat beat_q, capturing ram_rdata on ack
// WR_BEAT | issuing write beat beat_q from the latched line
// DONE    | one-cycle mem_ready pulse; read line published
module line_mem_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_SIZE  = 32,
  parameter int WORD_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  line_mem_bridge_if.slave  bus,
  output logic              busy,
  output logic              err_timeout
);
  localparam int LINE_BITS  = LINE_SIZE * 8;
  localparam int BEATS      = LINE_BITS / WORD_WIDTH;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TMO_W      = $clog2(TIMEOUT + 1);
  localparam int WORD_BYTES = WORD_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, RD_BEAT, WR_BEAT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [LINE_BITS-1:0]   wline_q, wline_d;
  logic [LINE_BITS-1:0]   rbuf_q, rbuf_d;
  logic [LINE_BITS-1:0]   rdata_q, rdata_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   err_q, err_d;

  logic                   ram_req;
  logic                   ram_we;
  logic                   mem_ready;
  logic                   tmo_hit;
  logic                   beat_end;
  logic                   last_beat;

  // A beat ends on ack, or on the final allowed wait cycle without one.
  assign tmo_hit   = !bus.ram_ack && (tmo_q == TMO_W'(TIMEOUT - 1));
  assign beat_end  = bus.ram_ack || tmo_hit;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    wline_d   = wline_q;
    rbuf_d    = rbuf_q;
    rdata_d   = rdata_q;
    beat_d    = beat_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    ram_req   = 1'b0;
    ram_we    = 1'b0;
    mem_ready = 1'b0;

    case (state_q)
      IDLE: begin
        beat_d = '0;
        tmo_d  = '0;
        if (bus.mem_write) begin
          base_d  = bus.mem_addr & ~ADDR_WIDTH'(LINE_SIZE - 1);
          wline_d = bus.mem_write_data;
          state_d = WR_BEAT;
        end else if (bus.mem_read) begin
          base_d  = bus.mem_addr & ~ADDR_WIDTH'(LINE_SIZE - 1);
          state_d = RD_BEAT;
        end
      end

      RD_BEAT, WR_BEAT: begin
        ram_req = 1'b1;
        ram_we  = (state_q == WR_BEAT);
        if (beat_end) begin
          // An abandoned read beat leaves zeros rather than stale data.
          if (state_q == RD_BEAT) begin
            rbuf_d[int'(beat_q)*WORD_WIDTH +: WORD_WIDTH] =
              bus.ram_ack ? bus.ram_rdata : '0;
          end
          if (tmo_hit) begin
            err_d = 1'b1;
          end
          tmo_d = '0;
          if (last_beat) begin
            beat_d  = '0;
            state_d = DONE;
            // The published line only changes when a read finishes, so it
            // stays valid through any later write or partial read.
            if (state_q == RD_BEAT) begin
              rdata_d = rbuf_d;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      DONE: begin
        mem_ready = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      wline_q <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
      beat_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      wline_q <= wline_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign bus.ram_req       = ram_req;
  assign bus.ram_we        = ram_we;
  assign bus.ram_addr      = base_q + ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(WORD_BYTES);
  assign bus.ram_wdata     = wline_q[int'(beat_q)*WORD_WIDTH +: WORD_WIDTH];
  assign bus.mem_ready     = mem_ready;
  assign bus.mem_read_data = rdata_q;
  assign busy              = (state_q != IDLE);
  assign err_timeout       = err_q;
endmodule

// File: tb/tb_line_mem_bridge.sv
// Bench for line_mem_bridge: a transaction-level model turns each request
// into the cycle-by-cycle schedule the bridge must produce, and a compare
// process checks every cycle against it.
module tb_line_mem_bridge;
  localparam int TMO = 4;

  logic clk;
  logic rst_n;
  logic busy;
  logic err_timeout;

  line_mem_bridge_if #(.ADDR_WIDTH(32), .LINE_SIZE(32), .WORD_WIDTH(32)) bus ();

  line_mem_bridge #(
    .ADDR_WIDTH(32), .LINE_SIZE(32), .WORD_WIDTH(32), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           req;
    bit           we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    bit           ready;
    bit           rd;
    logic [255:0] rdata;
    bit           tmo;
    bit           commit;
    bit           busy;
  } ent_t;

  ent_t         sched[$];
  logic [31:0]  ram_mem [0:1023];
  logic [31:0]  ref_mem [0:1023];
  int           dly [0:7];
  bit           exp_err;
  logic [255:0] exp_rbuf;
  int           checks;
  int           errors;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expand one line request into its expected per-cycle outputs.
  task automatic push_sched(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [255:0] wl, output int lat);
    logic [31:0]  base;
    logic [255:0] line;
    ent_t         e;
    int           dur;
    base = addr & ~32'd31;
    line = '0;
    lat  = 1;
    for (int b = 0; b < 8; b++) begin
      dur = (dly[b] >= TMO) ? TMO : dly[b] + 1;
      lat += dur;
      if (!wr && dly[b] < TMO) line[32*b +: 32] = ref_mem[(base[11:0] + 12'(4*b)) >> 2];
      for (int c = 0; c < dur; c++) begin
        e = '{default: 0};
        e.req    = 1;
        e.busy   = 1;
        e.we     = wr;
        e.addr   = base + 32'(4*b);
        e.wdata  = wl[32*b +: 32];
        e.tmo    = (dly[b] >= TMO) && (c == dur - 1);
        e.commit = wr && (dly[b] < TMO) && (c == dur - 1);
        sched.push_back(e);
      end
    end
    e = '{default: 0};
    e.ready = 1;
    e.busy  = 1;
    e.rd    = !wr && rd;
    e.rdata = line;
    sched.push_back(e);
  endtask

  task automatic xfer(input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [255:0] wl, input int exp_lat);
    int n;
    int lat;
    @(negedge clk);
    push_sched(rd, wr, addr, wl, lat);
    bus.mem_read       = rd;
    bus.mem_write      = wr;
    bus.mem_addr       = addr;
    bus.mem_write_data = wl;
    n = 0;
    while (!bus.mem_ready && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.mem_ready) begin
      checks++;
      errors++;
      $display("FAIL mem_ready_wait actual=none required=pulse within 500 cycles");
    end else begin
      chk("latency_model", 256'(n), 256'(lat));
      if (exp_lat > 0) chk("latency_lit", 256'(n), 256'(exp_lat));
    end
    @(negedge clk);
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_addr       = $urandom;
    bus.mem_write_data = {8{$urandom}};
  endtask

  // Cycle-by-cycle compare against the model schedule.
  initial begin
    ent_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sched.size() > 0) e = sched.pop_front();
      else                  e = '{default: 0};
      if (e.ready && e.rd) exp_rbuf = e.rdata;
      chk("ram_req", 256'(bus.ram_req), 256'(e.req));
      if (e.req) begin
        chk("ram_we", 256'(bus.ram_we), 256'(e.we));
        chk("ram_addr", 256'(bus.ram_addr), 256'(e.addr));
        if (e.we) chk("ram_wdata", 256'(bus.ram_wdata), 256'(e.wdata));
      end
      chk("mem_ready", 256'(bus.mem_ready), 256'(e.ready));
      chk("busy", 256'(busy), 256'(e.busy));
      chk("err_timeout", 256'(err_timeout), 256'(exp_err));
      chk("mem_read_data", bus.mem_read_data, exp_rbuf);
      if (e.tmo) exp_err = 1'b1;
      if (e.commit) ref_mem[e.addr[11:2]] = e.wdata;
    end
  end

  // RAM responder: acks beat b after dly[b] wait cycles; never if too long.
  initial begin
    bit          was_req;
    int          cnt;
    logic [31:0] last;
    was_req = 0;
    cnt     = 0;
    last    = '0;
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.ram_req === 1'b1) begin
        if (!was_req || bus.ram_addr != last) cnt = 0;
        else cnt++;
        last    = bus.ram_addr;
        was_req = 1;
        if (cnt == dly[bus.ram_addr[4:2]]) begin
          bus.ram_ack   = 1'b1;
          bus.ram_rdata = ram_mem[bus.ram_addr[11:2]];
          if (bus.ram_we) ram_mem[bus.ram_addr[11:2]] = bus.ram_wdata;
        end else begin
          bus.ram_ack   = 1'b0;
          bus.ram_rdata = $urandom;
        end
      end else begin
        was_req       = 0;
        bus.ram_ack   = 1'($urandom_range(0, 1));
        bus.ram_rdata = $urandom;
      end
    end
  end

  initial begin
    logic [255:0] wl;
    int           n;
    int           lat;
    checks   = 0;
    errors   = 0;
    exp_err  = 0;
    exp_rbuf = '0;
    for (int b = 0; b < 8; b++) dly[b] = 0;
    for (int i = 0; i < 1024; i++) ram_mem[i] = 32'h1000 + 32'(i & 7);
    for (int k = 0; k < 8; k++) ram_mem[32'hC0 + k] = 32'h3000 + 32'(k);
    for (int i = 0; i < 1024; i++) ref_mem[i] = ram_mem[i];
    rst_n              = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_write_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_err", 256'(err_timeout), 256'(0));
    chk("rst_rdata", bus.mem_read_data, 256'(0));
    chk("rst_ram_addr", 256'(bus.ram_addr), 256'(0));
    rst_n = 1'b1;

    // Zero-wait read of an unaligned address.
    xfer(1, 0, 32'h0000_0047, '0, 9);
    for (int k = 0; k < 8; k++)
      chk("rd_word", 256'(bus.mem_read_data[32*k +: 32]), 256'(32'h1000 + k));

    // Write with three wait cycles per beat.
    for (int b = 0; b < 8; b++) dly[b] = 3;
    for (int k = 0; k < 8; k++) wl[32*k +: 32] = 32'hA0 + 32'(k);
    xfer(0, 1, 32'h80, wl, 33);
    for (int k = 0; k < 8; k++) chk("wr_ram", 256'(ram_mem[32 + k]), 256'(32'hA0 + k));

    // Simultaneous read and write: write wins, read line untouched.
    for (int b = 0; b < 8; b++) dly[b] = 0;
    for (int k = 0; k < 8; k++) wl[32*k +: 32] = 32'hB0 + 32'(k);
    xfer(1, 1, 32'h100, wl, 9);
    chk("both_ram", 256'(ram_mem[32'h47]), 256'(32'hB7));
    chk("both_rdata_kept", 256'(bus.mem_read_data[31:0]), 256'(32'h1000));

    // Beat 3 never acked.
    dly[3] = 7;
    xfer(1, 0, 32'h180, '0, 12);
    chk("tmo_word3", 256'(bus.mem_read_data[96 +: 32]), 256'(0));
    chk("tmo_word4", 256'(bus.mem_read_data[128 +: 32]), 256'(32'h1004));
    chk("tmo_err", 256'(err_timeout), 256'(1));
    dly[3] = 0;
    xfer(1, 0, 32'h1C0, '0, 9);
    chk("tmo_err_sticky", 256'(err_timeout), 256'(1));

    // Reset during beat 5 of a write.
    for (int b = 0; b < 8; b++) dly[b] = 1;
    @(negedge clk);
    push_sched(0, 1, 32'h400, {8{32'hDEAD_0000}}, lat);
    bus.mem_write      = 1'b1;
    bus.mem_addr       = 32'h400;
    bus.mem_write_data = {8{32'hDEAD_0000}};
    n = 0;
    while (!(bus.ram_req === 1'b1 && bus.ram_addr == 32'h414) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rst_reached_beat5", 256'(bus.ram_addr), 256'(32'h414));
    @(negedge clk);
    rst_n         = 1'b0;
    bus.mem_write = 1'b0;
    sched.delete();
    exp_err  = 0;
    exp_rbuf = '0;
    @(posedge clk);
    #1;
    chk("abort_ram_req", 256'(bus.ram_req), 256'(0));
    chk("abort_busy", 256'(busy), 256'(0));
    chk("abort_rdata", bus.mem_read_data, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int b = 0; b < 8; b++) dly[b] = 0;
    xfer(1, 0, 32'h300, '0, 9);
    chk("post_rst_err", 256'(err_timeout), 256'(0));
    chk("post_rst_word0", 256'(bus.mem_read_data[31:0]), 256'(32'h3000));

    // Back-to-back reads.
    xfer(1, 0, 32'h200, '0, 9);
    chk("b2b_first", 256'(bus.mem_read_data[160 +: 32]), 256'(32'h1005));
    xfer(1, 0, 32'h300, '0, 9);
    chk("b2b_second", 256'(bus.mem_read_data[32 +: 32]), 256'(32'h3001));

    // Randomized traffic, occasional timeouts.
    for (int t = 0; t < 80; t++) begin
      int op;
      for (int b = 0; b < 8; b++)
        dly[b] = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO, TMO + 2) : $urandom_range(0, 2);
      for (int k = 0; k < 8; k++) wl[32*k +: 32] = $urandom;
      op = $urandom_range(0, 3);
      xfer(op != 2, op >= 2, 32'($urandom_range(0, 4095)), wl, 0);
    end
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
